// File: rtl/easyaxi_pkg.sv
// Shared AXI encodings and FSM state types for the easyaxi read-channel demo.
package easyaxi_pkg;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam int         BEAT_BYTES  = 4;
   localparam logic [2:0] BEAT_SIZE   = 3'd2;

   typedef enum logic [1:0] {
      M_IDLE,
      M_AR,
      M_R,
      M_DONE
   } mst_state_t;

   typedef enum logic {
      S_IDLE,
      S_DATA
   } slv_state_t;

endpackage

// File: rtl/easyaxi_mst.sv
// AXI read master: issues NUM_TXN fixed INCR bursts, checks every returned beat.
module easyaxi_mst
   import easyaxi_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ID_WIDTH   = 4,
   parameter int                    BURST_LEN  = 3,
   parameter int                    NUM_TXN    = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000,
   parameter int                    CNT_W      = $clog2(NUM_TXN + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   output logic                  arvalid,
   input  logic                  arready,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [ID_WIDTH-1:0]   arid,
   output logic [7:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   input  logic                  rvalid,
   output logic                  rready,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic [ID_WIDTH-1:0]   rid,
   input  logic                  rlast,
   output logic                  done,
   output logic                  err,
   output logic [CNT_W-1:0]      txn_cnt
);

   localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'((BURST_LEN + 1) * BEAT_BYTES);
   localparam logic [CNT_W-1:0]      LAST_TXN    = CNT_W'(NUM_TXN);
   localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LEN);

   mst_state_t            state, state_nxt;
   logic [CNT_W-1:0]      txn_q;
   logic [7:0]            beat_q;
   logic                  err_q;
   logic                  beat_hs;
   logic                  beat_bad;
   logic [ADDR_WIDTH-1:0] beat_addr;

   // Payload derives only from txn_q, which cannot change while arvalid is high.
   assign araddr  = BASE_ADDR + ADDR_WIDTH'(txn_q) * BURST_BYTES;
   assign arid    = ID_WIDTH'(txn_q);
   assign arlen   = LAST_BEAT;
   assign arsize  = BEAT_SIZE;
   assign arburst = BURST_INCR;

   assign beat_addr = araddr + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BEAT_BYTES);
   assign beat_hs   = rvalid && rready;
   assign beat_bad  = (rdata != DATA_WIDTH'(beat_addr)) ||
                      (rresp != RESP_OKAY) ||
                      (rid != arid) ||
                      (rlast != (beat_q == LAST_BEAT));

   always_comb begin
      state_nxt = state;
      arvalid   = 1'b0;
      rready    = 1'b0;
      case (state)
         M_IDLE: begin
            if (txn_q == LAST_TXN)
               state_nxt = M_DONE;
            else if (enable)
               state_nxt = M_AR;
         end
         M_AR: begin
            arvalid = 1'b1;
            if (arready)
               state_nxt = M_R;
         end
         M_R: begin
            rready = 1'b1;
            if (rvalid && rlast)
               state_nxt = M_IDLE;
         end
         M_DONE:  state_nxt = M_DONE;
         default: state_nxt = M_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= M_IDLE;
         txn_q  <= '0;
         beat_q <= '0;
         err_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (beat_hs) begin
            err_q <= err_q | beat_bad;
            if (rlast) begin
               beat_q <= '0;
               txn_q  <= txn_q + 1'b1;
            end else begin
               beat_q <= beat_q + 8'd1;
            end
         end
      end
   end

   assign done    = (state == M_DONE);
   assign err     = err_q;
   assign txn_cnt = txn_q;

endmodule

// File: rtl/easyaxi_slv.sv
// AXI read slave: accepts one burst at a time, returns address-derived data beats.
module easyaxi_slv
   import easyaxi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  arvalid,
   output logic                  arready,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  logic [ID_WIDTH-1:0]   arid,
   input  logic [7:0]            arlen,
   input  logic [2:0]            arsize,
   input  logic [1:0]            arburst,
   output logic                  rvalid,
   input  logic                  rready,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            rresp,
   output logic [ID_WIDTH-1:0]   rid,
   output logic                  rlast
);

   slv_state_t            state, state_nxt;
   logic                  ar_en_q;
   logic [7:0]            beat_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic                  ok_q;
   logic                  ar_hs;

   // ar_en_q keeps arready low while in reset and for the first cycle after release.
   assign arready = ar_en_q && (state == S_IDLE);
   assign ar_hs   = arvalid && arready;
   assign rvalid  = (state == S_DATA);
   assign rdata   = DATA_WIDTH'(addr_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BEAT_BYTES));
   assign rid     = id_q;
   assign rlast   = rvalid && (beat_q == len_q);
   assign rresp   = ok_q ? RESP_OKAY : RESP_SLVERR;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (ar_hs) state_nxt = S_DATA;
         S_DATA:  if (rready && rlast) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ar_en_q <= 1'b0;
         beat_q  <= '0;
      end else begin
         state   <= state_nxt;
         ar_en_q <= 1'b1;
         if (ar_hs)
            beat_q <= '0;
         else if (rvalid && rready)
            beat_q <= rlast ? 8'd0 : beat_q + 8'd1;
      end
   end

   // Only fixed-size INCR bursts are supported; anything else is answered with SLVERR.
   always_ff @(posedge clk) begin
      if (ar_hs) begin
         addr_q <= araddr;
         len_q  <= arlen;
         id_q   <= arid;
         ok_q   <= (arburst == BURST_INCR) && (arsize == BEAT_SIZE);
      end
   end

endmodule

// File: rtl/easyaxi_top.sv
// Back-to-back AXI read master and slave over AR/R; exports completion and error status.
module easyaxi_top
   import easyaxi_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ID_WIDTH   = 4,
   parameter int                    BURST_LEN  = 3,
   parameter int                    NUM_TXN    = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   output logic                         done,
   output logic                         err,
   output logic [$clog2(NUM_TXN+1)-1:0] txn_cnt
);

   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [ID_WIDTH-1:0]   arid;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic [ID_WIDTH-1:0]   rid;
   logic                  rlast;

   easyaxi_mst #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ID_WIDTH   (ID_WIDTH),
      .BURST_LEN  (BURST_LEN),
      .NUM_TXN    (NUM_TXN),
      .BASE_ADDR  (BASE_ADDR),
      .CNT_W      ($clog2(NUM_TXN + 1))
   ) u_mst (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .arvalid (arvalid),
      .arready (arready),
      .araddr  (araddr),
      .arid    (arid),
      .arlen   (arlen),
      .arsize  (arsize),
      .arburst (arburst),
      .rvalid  (rvalid),
      .rready  (rready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rid     (rid),
      .rlast   (rlast),
      .done    (done),
      .err     (err),
      .txn_cnt (txn_cnt)
   );

   easyaxi_slv #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ID_WIDTH   (ID_WIDTH)
   ) u_slv (
      .clk     (clk),
      .rst_n   (rst_n),
      .arvalid (arvalid),
      .arready (arready),
      .araddr  (araddr),
      .arid    (arid),
      .arlen   (arlen),
      .arsize  (arsize),
      .arburst (arburst),
      .rvalid  (rvalid),
      .rready  (rready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rid     (rid),
      .rlast   (rlast)
   );

endmodule

// File: tb/tb_easyaxi_top.sv
// Scoreboard bench for easyaxi_top: expected AR/R traffic queued per scenario, popped by a monitor.
module tb_easyaxi_top;
   import easyaxi_pkg::*;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       enable = 1'b0;
   logic       done;
   logic       err;
   logic [2:0] txn_cnt;

   always #5 clk = ~clk;

   easyaxi_top dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .done    (done),
      .err     (err),
      .txn_cnt (txn_cnt)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  id;
   } ar_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  id;
      logic        last;
   } r_t;

   ar_t ar_q[$];
   r_t  r_q[$];
   int  checks = 0;
   int  errors = 0;
   bit  fault_on = 1'b0;
   logic [31:0] fault_val;

   // Hand-computed burst start addresses and beat offsets.
   logic [31:0] burst_addr [4] = '{32'h0000_1000, 32'h0000_1010, 32'h0000_1020, 32'h0000_1030};
   logic [31:0] beat_off   [4] = '{32'h0, 32'h4, 32'h8, 32'hC};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_all();
      ar_t a;
      r_t  r;
      ar_q.delete();
      r_q.delete();
      for (int k = 0; k < 4; k++) begin
         a.addr = burst_addr[k];
         a.id   = 4'(k);
         ar_q.push_back(a);
         for (int b = 0; b < 4; b++) begin
            r.data = burst_addr[k] + beat_off[b];
            r.id   = 4'(k);
            r.last = (b == 3);
            r_q.push_back(r);
         end
      end
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      enable = 1'b0;
      ar_q.delete();
      r_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_done(input string name, input int max);
      int i = 0;
      while (!done && i < max) begin
         @(posedge clk); #1;
         i++;
      end
      check(name, 32'(done), 32'd1);
   endtask

   task automatic wait_burst_r(input string name, input logic [2:0] k, input int max);
      int i = 0;
      while (!(txn_cnt == k && dut.rvalid) && i < max) begin
         @(posedge clk); #1;
         i++;
      end
      check(name, 32'(txn_cnt == k && dut.rvalid), 32'd1);
   endtask

   task automatic wait_txn(input string name, input logic [2:0] k, input int max);
      int i = 0;
      while (txn_cnt != k && i < max) begin
         @(posedge clk); #1;
         i++;
      end
      check(name, 32'(txn_cnt), 32'(k));
   endtask

   // Monitor state
   ar_t         m_ea;
   r_t          m_er;
   int          m_beats  = 0;
   logic        m_p_arv  = 1'b0;
   logic        m_p_arr  = 1'b0;
   logic        m_p_rv   = 1'b0;
   logic        m_p_rr   = 1'b0;
   logic [31:0] m_p_addr = '0;
   logic [31:0] m_p_data = '0;
   logic        m_p_last = 1'b0;

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_beats = 0;
            m_p_arv = 1'b0;
            m_p_rv  = 1'b0;
         end else begin
            if (m_p_arv && !m_p_arr) begin
               check("ar_valid_held", 32'(dut.arvalid), 32'd1);
               check("ar_addr_stable", dut.araddr, m_p_addr);
            end
            if (m_p_rv && !m_p_rr) begin
               check("r_data_stable", dut.rdata, m_p_data);
               check("r_last_stable", 32'(dut.rlast), 32'(m_p_last));
            end
            if (dut.arvalid && dut.arready) begin
               if (ar_q.size() == 0) begin
                  check("ar_unexpected", 32'(ar_q.size()), 32'd1);
               end else begin
                  m_ea = ar_q.pop_front();
                  check("araddr", dut.araddr, m_ea.addr);
                  check("arid", 32'(dut.arid), 32'(m_ea.id));
                  check("arlen", 32'(dut.arlen), 32'd3);
                  check("arsize", 32'(dut.arsize), 32'd2);
                  check("arburst", 32'(dut.arburst), 32'(BURST_INCR));
               end
            end
            if (dut.rvalid && dut.rready) begin
               m_beats++;
               if (r_q.size() == 0) begin
                  check("r_unexpected", 32'(r_q.size()), 32'd1);
               end else begin
                  m_er = r_q.pop_front();
                  if (!fault_on)
                     check("rdata", dut.rdata, m_er.data);
                  check("rid", 32'(dut.rid), 32'(m_er.id));
                  check("rlast", 32'(dut.rlast), 32'(m_er.last));
                  check("rresp", 32'(dut.rresp), 32'(RESP_OKAY));
               end
               if (dut.rlast) begin
                  check("beats_per_burst", 32'(m_beats), 32'd4);
                  m_beats = 0;
               end
            end
            m_p_arv  = dut.arvalid;
            m_p_arr  = dut.arready;
            m_p_addr = dut.araddr;
            m_p_rv   = dut.rvalid;
            m_p_rr   = dut.rready;
            m_p_data = dut.rdata;
            m_p_last = dut.rlast;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      // Reset values while rst_n is held low
      rst_n  = 1'b0;
      enable = 1'b0;
      #12;
      check("rst_arvalid", 32'(dut.arvalid), 32'd0);
      check("rst_arready", 32'(dut.arready), 32'd0);
      check("rst_rvalid", 32'(dut.rvalid), 32'd0);
      check("rst_rready", 32'(dut.rready), 32'd0);
      check("rst_rlast", 32'(dut.rlast), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_txn_cnt", 32'(txn_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // enable held low: nothing may be issued
      repeat (100) @(posedge clk);
      #1;
      check("idle_arvalid", 32'(dut.arvalid), 32'd0);
      check("idle_txn_cnt", 32'(txn_cnt), 32'd0);
      check("idle_done", 32'(done), 32'd0);

      // Full run, enable six cycles after release
      do_reset();
      repeat (6) @(posedge clk);
      #1;
      push_all();
      enable = 1'b1;
      wait_done("main_done", 50);
      check("main_err", 32'(err), 32'd0);
      check("main_txn_cnt", 32'(txn_cnt), 32'd4);
      check("main_ar_left", 32'(ar_q.size()), 32'd0);
      check("main_r_left", 32'(r_q.size()), 32'd0);

      // Drop enable during the second burst's R phase
      do_reset();
      push_all();
      enable = 1'b1;
      wait_burst_r("pause_burst2_r", 3'd1, 40);
      enable = 1'b0;
      wait_txn("pause_burst2_done", 3'd2, 20);
      repeat (20) @(posedge clk);
      #1;
      check("pause_txn_hold", 32'(txn_cnt), 32'd2);
      check("pause_done", 32'(done), 32'd0);
      check("pause_arvalid", 32'(dut.arvalid), 32'd0);
      check("pause_ar_left", 32'(ar_q.size()), 32'd2);
      enable = 1'b1;
      wait_done("resume_done", 50);
      check("resume_txn_cnt", 32'(txn_cnt), 32'd4);

      // Asynchronous reset in the middle of a burst
      do_reset();
      push_all();
      enable = 1'b1;
      wait_burst_r("midrst_burst2_r", 3'd1, 40);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_rvalid", 32'(dut.rvalid), 32'd0);
      check("midrst_arvalid", 32'(dut.arvalid), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_err", 32'(err), 32'd0);
      check("midrst_txn_cnt", 32'(txn_cnt), 32'd0);
      ar_q.delete();
      r_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      push_all();
      rst_n = 1'b1;
      wait_done("midrst_done_after", 50);
      check("midrst_txn_after", 32'(txn_cnt), 32'd4);
      check("midrst_err_after", 32'(err), 32'd0);
      check("midrst_ar_left", 32'(ar_q.size()), 32'd0);

      // Corrupt rdata LSB on the first beat of the first burst
      do_reset();
      push_all();
      enable = 1'b1;
      wait_burst_r("fault_first_beat", 3'd0, 20);
      fault_val = dut.rdata ^ 32'h1;
      fault_on  = 1'b1;
      force dut.rdata = fault_val;
      @(posedge clk);
      #1;
      release dut.rdata;
      fault_on = 1'b0;
      check("fault_err_set", 32'(err), 32'd1);
      wait_done("fault_done", 50);
      check("fault_err_at_done", 32'(err), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("fault_err_sticky", 32'(err), 32'd1);
      check("fault_txn_cnt", 32'(txn_cnt), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/easyaxi_top.md
Name: easyaxi_top

Overview:
- Self-contained AXI4 read-channel demo top: an AXI master and an AXI slave connected back-to-back over the AR and R channels.
- After reset, once `enable` is high, the master issues a fixed sequence of INCR read bursts. The slave answers each with deterministic, address-derived data. The master checks every beat.
- Sits directly under the simulation top. Only clock, reset and `enable` are driven; status outputs are exported for checking.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width (fixed 4-byte beats, arsize=2).
- ID_WIDTH, 4, AXI ID width.
- BURST_LEN, 3, arlen value (beats per burst = BURST_LEN+1).
- NUM_TXN, 4, number of bursts the master issues.
- BASE_ADDR, 32'h0000_1000, address of the first burst.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; master may start a new burst only while high.
- done  out  1  high once all NUM_TXN bursts have completed; sticky until reset.
- err  out  1  sticky; set on any check failure.
- txn_cnt  out  $clog2(NUM_TXN+1)  number of completed bursts.

Behaviour:
- Reset (async assert, sync release): all FSMs IDLE; arvalid=0, rvalid=0, rlast=0, arready=0, rready=0; done=0, err=0, txn_cnt=0.
- Master FSM states: IDLE -> AR -> R -> IDLE, then DONE after the last burst.
  - IDLE: if enable=1 and txn_cnt<NUM_TXN, go to AR next cycle.
  - If txn_cnt==NUM_TXN, go to DONE and set done=1.
- AR state: master drives arvalid=1 with fixed payload until the arvalid&arready handshake; on handshake go to R.
  - araddr = BASE_ADDR + k*(BURST_LEN+1)*4, where k = txn_cnt.
  - arid = k[ID_WIDTH-1:0]; arlen = BURST_LEN; arsize = 2; arburst = INCR.
  - AXI rule: arvalid never drops before handshake; payload stable while arvalid=1.
- R state: rready=1. Each rvalid&rready handshake is one beat; the master checks:
  - rdata == araddr + beat*4;
  - rresp == OKAY (2'b00);
  - rid == arid;
  - rlast == (beat==BURST_LEN).
  - Any mismatch sets err (sticky); the transaction still proceeds.
  - On the rlast handshake: txn_cnt += 1, return to IDLE.
- enable deasserted mid-burst: the current burst completes normally; no new burst starts until enable=1 again.
- Slave states: IDLE (arready=1) and DATA (arready=0).
  - On AR handshake: latch addr, len, id; enter DATA.
  - rvalid=1 from the next cycle; rdata = latched addr + beat*4; rresp=OKAY; rid = latched id; rlast=1 on beat==len.
  - Beat advances only on rvalid&rready; rdata/rlast stay stable while rvalid=1 and rready=0.
  - After the rlast handshake: rvalid=0, return to IDLE.
- Latency: first R beat is valid 1 cycle after the AR handshake. Back-to-back beats at 1 per cycle. Roughly 7 cycles per burst; done must assert within 50 cycles of enable rising with defaults.
- Address arithmetic is modulo 2^ADDR_WIDTH; rdata is the address truncated or zero-extended to DATA_WIDTH.
- Reset mid-burst: everything returns to reset values immediately; the sequence restarts from k=0 after release.

Decomposition:
- Shared package: AXI burst/resp encodings (BURST_INCR=2'b01, RESP_OKAY=2'b00), and a beat-size constant (4 bytes / arsize=2).
- Two sub-modules, instantiated by the top and wired together:
  - easyaxi_mst: AR issue, R checking, txn counter.
  - easyaxi_slv: AR accept, R generation.

Test Plan:
- Reset, enable=1 six cycles after release:
  - 4 AR handshakes at addrs 0x1000, 0x1010, 0x1020, 0x1030 with arid 0..3.
  - Each burst returns 4 beats, e.g. 0x1000, 0x1004, 0x1008, 0x100C; rlast on the 4th beat.
  - done=1, err=0, txn_cnt=4.
- enable held 0 after reset for 100 cycles -> arvalid stays 0, txn_cnt=0, done=0.
- Drop enable during the 2nd burst's R phase -> burst 2 completes; txn_cnt holds at 2; resumes to 4 when enable returns to 1.
- Assert rst_n=0 mid-burst -> rvalid, arvalid, done, err and txn_cnt go to 0 asynchronously; after release the sequence restarts at addr 0x1000.
- Force the slave rdata LSB inverted on one beat (fault injection) -> err=1 and stays 1; done still reaches 1.
- Protocol checks over the whole run:
  - arvalid never drops before arready.
  - rdata/rlast stable while rvalid=1 and rready=0.
  - Exactly BURST_LEN+1 beats per burst.
